// File: rtl/smart_home_pkg.sv
// Shared types and widths for the smart-home sensor conditioning blocks.
package smart_home_pkg;

    localparam int unsigned EVENT_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        QUAL_ON,
        ACTIVE,
        QUAL_OFF,
        LOCKOUT
    } ir_state_e;

endpackage : smart_home_pkg

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module bit_synchronizer #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    if (STAGES < 2) begin : g_bad_stages
        $error("bit_synchronizer: STAGES must be >= 2");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/ir_motion_conditioner.sv
// Debounces the IR sensor, applies a post-detection lockout and produces
// a toggling enable, a detection level, an event strobe and an event count.
module ir_motion_conditioner
    import smart_home_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLDOFF_CYCLES  = 2500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ir_raw,
    input  logic                   arm,
    input  logic                   clear_count,
    output logic                   enable,
    output logic                   detect,
    output logic                   motion_pulse,
    output logic [EVENT_CNT_W-1:0] event_count
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ?
                                      DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [EVENT_CNT_W-1:0] COUNT_MAX = '1;
    localparam logic IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ir_motion_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("ir_motion_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLDOFF_CYCLES < 1) begin : g_bad_hold
        $error("ir_motion_conditioner: HOLDOFF_CYCLES must be >= 1");
    end

    logic             ir_sync;
    logic             hit;
    ir_state_e        state;
    logic [CNT_W-1:0] cnt;

    bit_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (IDLE_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ir_raw),
        .q   (ir_sync)
    );

    assign hit = ACTIVE_LOW ? ~ir_sync : ir_sync;

    // Detection FSM; cnt is shared between debounce and holdoff timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            enable       <= 1'b0;
            detect       <= 1'b0;
            motion_pulse <= 1'b0;
            event_count  <= '0;
        end else begin
            motion_pulse <= 1'b0;
            if (clear_count) begin
                event_count <= '0;
            end
            case (state)
                IDLE: begin
                    if (hit) begin
                        state <= QUAL_ON;
                        cnt   <= '0;
                    end
                end
                QUAL_ON: begin
                    if (!hit) begin
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state        <= ACTIVE;
                        detect       <= 1'b1;
                        motion_pulse <= 1'b1;
                        if (arm) begin
                            enable <= ~enable;
                            // clear_count has priority over the increment
                            if (!clear_count && event_count != COUNT_MAX) begin
                                event_count <= event_count + EVENT_CNT_W'(1);
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (!hit) begin
                        state <= QUAL_OFF;
                        cnt   <= '0;
                    end
                end
                QUAL_OFF: begin
                    if (hit) begin
                        state <= ACTIVE;
                    end else if (cnt == DEB_LAST) begin
                        state  <= LOCKOUT;
                        cnt    <= '0;
                        detect <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOCKOUT: begin
                    if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : ir_motion_conditioner
